lcd_frame_sequencer: RTL and testbench

Holds a 2-row × 16-column character frame buffer and streams it to the HD44780 LCD bus driver as command/data bytes over a valid/ready handshake. Sits directly upstream of the LCD bus driver: application logic writes characters by position, and this block turns each changed frame into the byte sequence the driver clocks onto DB7-0 with RS.

---
 rtl/lcd_frame_sequencer_if.sv | 42 ++++
 rtl/lcd_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_frame_sequencer_if
//
// Purpose:
//   Bundles the character-write port and the byte-stream handshake of
//   lcd_frame_sequencer. The application/driver side uses the master
//   modport; the sequencer itself uses the slave modport.
//
// Signals:
//   wr_en      app -> seq   write one character this cycle
//   wr_addr    app -> seq   buffer index, row*COLS + col (5 bits)
//   wr_char    app -> seq   character code to store
//   clear      app -> seq   fill the whole buffer with spaces
//   out_valid  seq -> drv   byte presented
//   out_rs     seq -> drv   0 = command byte, 1 = character byte
//   out_data   seq -> drv   byte value
//   out_ready  drv -> seq   driver accepts the byte at this clock edge
//   busy       seq -> app   frame transfer in progress
//   frame_done seq -> app   one-cycle pulse after the last byte of a frame
// ---------------------------------------------------------------------------
interface lcd_frame_sequencer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       clear;
  logic       out_valid;
  logic       out_rs;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       frame_done;

  modport master (
    output wr_en, wr_addr, wr_char, clear, out_ready,
    input  out_valid, out_rs, out_data, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, clear, out_ready,
    output out_valid, out_rs, out_data, busy, frame_done
  );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_frame_sequencer
//
// Purpose:
//   Holds a 2-row x COLS-column character frame buffer and, whenever the
//   buffer has changed, streams the whole frame to the HD44780 bus driver
//   as: ROW0_CMD, COLS row-0 characters, ROW1_CMD, COLS row-1 characters
//   (2*COLS+2 bytes). Bytes leave over a valid/ready handshake.
//
// Parameters:
//   COLS      characters per row (>= 2; 2*COLS must fit the 5-bit address)
//   ROW0_CMD  set-DDRAM-address command for row 0
//   ROW1_CMD  set-DDRAM-address command for row 1
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   lcd_frame_sequencer_if.slave: write port (wr_en, wr_addr,
//         wr_char, clear), byte stream (out_valid, out_rs, out_data,
//         out_ready) and status (busy, frame_done)
// ---------------------------------------------------------------------------
module lcd_frame_sequencer #(
  parameter int         COLS     = 16,
  parameter logic [7:0] ROW0_CMD = 8'h80,
  parameter logic [7:0] ROW1_CMD = 8'hC0
) (
  input logic                  clk,
  input logic                  rst,
  lcd_frame_sequencer_if.slave bus
);

  localparam int               ENTRIES  = 2 * COLS;
  localparam int               COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [7:0]       SPACE    = 8'h20;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR0  = 3'd1;
  localparam logic [2:0] CHARS0 = 3'd2;
  localparam logic [2:0] ADDR1  = 3'd3;
  localparam logic [2:0] CHARS1 = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             dirty_q, dirty_d;
  logic [7:0]       char_q [ENTRIES];
  logic [7:0]       char_d [ENTRIES];
  logic             out_valid_q, out_valid_d;
  logic             out_rs_q, out_rs_d;
  logic [7:0]       out_data_q, out_data_d;

  logic             wr_hit;
  logic             xfer;
  logic             load_char;
  int               rd_idx;

  // Indexes at or beyond 2*COLS are dropped without touching dirty.
  assign wr_hit = bus.wr_en && ({27'b0, bus.wr_addr} < 32'(ENTRIES));
  assign xfer   = out_valid_q && bus.out_ready;

  // Clear first, then a same-cycle write lands on top of the spaces.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      char_d[i] = char_q[i];
      if (bus.clear) begin
        char_d[i] = SPACE;
      end
      if (wr_hit && ({27'b0, bus.wr_addr} == 32'(i))) begin
        char_d[i] = bus.wr_char;
      end
    end
  end

  // Starting a frame clears dirty, but a write in that same cycle wins so
  // that the change is guaranteed to reach the display in a later frame.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == IDLE && dirty_q) begin
      dirty_d = 1'b0;
    end
    if (wr_hit || bus.clear) begin
      dirty_d = 1'b1;
    end
  end

  // The next byte is loaded into the output register on the same edge that
  // the current one transfers, so out_valid can stay high for the whole
  // frame. Character bytes are read from the registered buffer at load
  // time; afterwards the output register holds them regardless of writes.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_rs_d    = out_rs_q;
    out_data_d  = out_data_q;
    load_char   = 1'b0;
    rd_idx      = 0;

    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          state_d     = ADDR0;
          out_valid_d = 1'b1;
          out_rs_d    = 1'b0;
          out_data_d  = ROW0_CMD;
        end
      end
      ADDR0: begin
        if (xfer) begin
          state_d   = CHARS0;
          col_d     = '0;
          load_char = 1'b1;
          rd_idx    = 0;
        end
      end
      CHARS0: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            state_d    = ADDR1;
            col_d      = '0;
            out_rs_d   = 1'b0;
            out_data_d = ROW1_CMD;
          end else begin
            col_d     = col_q + 1'b1;
            load_char = 1'b1;
            rd_idx    = 32'(col_q) + 1;
          end
        end
      end
      ADDR1: begin
        if (xfer) begin
          state_d   = CHARS1;
          col_d     = '0;
          load_char = 1'b1;
          rd_idx    = COLS;
        end
      end
      CHARS1: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            state_d     = DONE;
            col_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            col_d     = col_q + 1'b1;
            load_char = 1'b1;
            rd_idx    = COLS + 32'(col_q) + 1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (load_char) begin
      out_rs_d = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (i == rd_idx) begin
          out_data_d = char_q[i];
        end
      end
    end
  end

  // Reset blanks the buffer and marks it dirty so the first frame after
  // reset clears whatever the display was showing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      dirty_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_rs_q    <= 1'b0;
      out_data_q  <= 8'h00;
      for (int i = 0; i < ENTRIES; i++) begin
        char_q[i] <= SPACE;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dirty_q     <= dirty_d;
      out_valid_q <= out_valid_d;
      out_rs_q    <= out_rs_d;
      out_data_q  <= out_data_d;
      char_q      <= char_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_rs     = out_rs_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_sequencer
//
// Directed bench for lcd_frame_sequencer. A second instance with COLS=8 is
// used for out-of-range writes, since the 5-bit index of the default
// 16-column instance cannot express an address >= 32.
// ---------------------------------------------------------------------------
module tb_lcd_frame_sequencer;

  logic clk = 1'b0;
  logic rst;

  lcd_frame_sequencer_if bus ();
  lcd_frame_sequencer_if bus2 ();

  lcd_frame_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lcd_frame_sequencer #(.COLS(8)) dut_narrow (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_buf [32];
  logic [8:0] cap_q [$];

  // Record every byte that will transfer at the coming rising edge.
  always begin
    @(negedge clk);
    #3;
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      cap_q.push_back({bus.out_rs, bus.out_data});
    end
  end

  // Expected {rs, data} of byte k (0-based) of a frame built from model_buf.
  function automatic logic [8:0] exp_byte(input int k);
    if (k == 0)       return {1'b0, 8'h80};
    else if (k <= 16) return {1'b1, model_buf[k-1]};
    else if (k == 17) return {1'b0, 8'hC0};
    else              return {1'b1, model_buf[k-2]};
  endfunction

  task automatic model_blank;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
  endtask

  task automatic wait_frame(input int max_cycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        seen   = 1'b1;
        cycles = c;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.out_valid === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int         fd_cycle;
    logic [8:0] got;
    bus.wr_en = 0;  bus.wr_addr = '0;  bus.wr_char = '0;  bus.clear = 0;  bus.out_ready = 1;
    bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_char = '0; bus2.clear = 0; bus2.out_ready = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_rs !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_rs: got %b expected 0", bus.out_rs); end
    checks++;
    if (bus.out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 00", bus.out_data); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end

    rst = 1'b1;
    cap_q.delete();
    model_blank();
    fd_cycle = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({bus.busy, bus.out_valid, bus.out_rs, bus.out_data} !== {3'b110, 8'h80}) begin
          failures++;
          $display("[TB] FAIL start_latency: got busy/valid/rs/data %b%b%b/%h expected 110/80",
                   bus.busy, bus.out_valid, bus.out_rs, bus.out_data);
        end
      end
      if (bus.frame_done === 1'b1) begin
        fd_cycle = c;
        break;
      end
    end
    checks++;
    if (fd_cycle != 35) begin failures++; $display("[TB] FAIL blank_frame_done_cycle: got %0d expected 35", fd_cycle); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL blank_frame_len: got %0d expected 34", cap_q.size()); end
    for (int k = 0; k < 34; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL blank_frame_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_done, bus.busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL after_done: got frame_done/busy %b%b expected 00", bus.frame_done, bus.busy);
    end
  endtask

  task automatic test_write_idle;
    int         cyc;
    bit         seen;
    bit         ok;
    logic [8:0] got;
    cap_q.delete();
    model_buf[0]  = 8'h48;
    model_buf[17] = 8'h69;
    bus.wr_en = 1; bus.wr_addr = 5'd0;  bus.wr_char = 8'h48;
    @(negedge clk);
    bus.wr_addr = 5'd17; bus.wr_char = 8'h69;
    @(negedge clk);
    bus.wr_en = 0;
    wait_frame(100, cyc, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL write_idle_done: got no frame_done expected pulse"); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL write_idle_len: got %0d expected 34", cap_q.size()); end
    for (int k = 0; k < 34; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL write_idle_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL write_idle_drain: got busy expected idle"); end
  endtask

  task automatic test_backpressure;
    bit         prev_stall;
    logic       prev_rs;
    logic [7:0] prev_data;
    bit         done;
    bit         ok;
    logic [8:0] got;
    cap_q.delete();
    model_buf[5] = 8'h58;
    bus.wr_en = 1; bus.wr_addr = 5'd5; bus.wr_char = 8'h58;
    @(negedge clk);
    bus.wr_en  = 0;
    prev_stall = 1'b0;
    prev_rs    = 1'b0;
    prev_data  = 8'h00;
    done       = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (prev_stall) begin
        checks++;
        if ({bus.out_valid, bus.out_rs, bus.out_data} !== {1'b1, prev_rs, prev_data}) begin
          failures++;
          $display("[TB] FAIL stall_hold: got valid/rs/data %b/%b/%h expected 1/%b/%h",
                   bus.out_valid, bus.out_rs, bus.out_data, prev_rs, prev_data);
        end
      end
      if (bus.frame_done === 1'b1) begin
        done = 1'b1;
        break;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      prev_stall    = bus.out_valid && !bus.out_ready;
      prev_rs       = bus.out_rs;
      prev_data     = bus.out_data;
      @(negedge clk);
    end
    bus.out_ready = 1;
    checks++;
    if (!done) begin failures++; $display("[TB] FAIL backpressure_done: got no frame_done expected pulse"); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL backpressure_len: got %0d expected 34", cap_q.size()); end
    for (int k = 0; k < 34; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL backpressure_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL backpressure_drain: got busy expected idle"); end
  endtask

  task automatic test_midframe_write;
    int         n_valid;
    bit         seen;
    bit         ok;
    logic [8:0] got;
    cap_q.delete();
    model_buf[10] = 8'h4B;
    bus.wr_en = 1; bus.wr_addr = 5'd10; bus.wr_char = 8'h4B;
    @(negedge clk);
    n_valid = 0;
    seen    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.wr_en = 0;
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.out_valid === 1'b1) begin
        n_valid++;
        if (n_valid == 5) begin
          bus.wr_en = 1; bus.wr_addr = 5'd31; bus.wr_char = 8'h41;
          model_buf[31] = 8'h41;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL midframe_done: got no frame_done expected pulse"); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL midframe_len: got %0d expected 34", cap_q.size()); end
    got = (cap_q.size() >= 34) ? cap_q[33] : 9'h000;
    checks++;
    if (got !== {1'b1, 8'h41}) begin failures++; $display("[TB] FAIL midframe_byte34: got %h expected 141", got); end
    for (int k = 0; k < 33; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL midframe_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_rs, bus.out_data} !== {2'b10, 8'h80}) begin
      failures++;
      $display("[TB] FAIL second_frame_start: got valid/rs/data %b/%b/%h expected 1/0/80",
               bus.out_valid, bus.out_rs, bus.out_data);
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL midframe_drain: got busy expected idle"); end
  endtask

  task automatic test_clear_write;
    int         cyc;
    bit         seen;
    bit         ok;
    logic [8:0] got;
    cap_q.delete();
    model_blank();
    model_buf[3] = 8'h5A;
    bus.clear = 1; bus.wr_en = 1; bus.wr_addr = 5'd3; bus.wr_char = 8'h5A;
    @(negedge clk);
    bus.clear = 0; bus.wr_en = 0;
    wait_frame(100, cyc, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL clear_done: got no frame_done expected pulse"); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL clear_len: got %0d expected 34", cap_q.size()); end
    for (int k = 0; k < 34; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL clear_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL clear_drain: got busy expected idle"); end
  endtask

  task automatic test_out_of_range;
    bit any_busy;
    bit seen;
    checks++;
    if (bus2.busy !== 1'b0) begin failures++; $display("[TB] FAIL narrow_idle: got busy %b expected 0", bus2.busy); end
    bus2.wr_en = 1; bus2.wr_addr = 5'd20; bus2.wr_char = 8'h41;
    @(negedge clk);
    bus2.wr_addr = 5'd16;
    @(negedge clk);
    bus2.wr_en = 0;
    any_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus2.busy !== 1'b0 || bus2.out_valid !== 1'b0) any_busy = 1'b1;
    end
    checks++;
    if (any_busy) begin failures++; $display("[TB] FAIL out_of_range_no_frame: got frame start expected none"); end
    bus2.wr_en = 1; bus2.wr_addr = 5'd3; bus2.wr_char = 8'h5A;
    @(negedge clk);
    bus2.wr_en = 0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus2.busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL in_range_starts_frame: got idle expected busy"); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int         n_valid;
    bit         reached;
    int         fd_cycle;
    bit         ok;
    logic [8:0] got;
    cap_q.delete();
    model_buf[0] = 8'h5A;
    bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_char = 8'h5A;
    @(negedge clk);
    bus.wr_en = 0;
    n_valid = 0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.out_valid === 1'b1) begin
        n_valid++;
        if (n_valid == 10) begin
          bus.out_ready = 0;
          reached = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin failures++; $display("[TB] FAIL reach_byte10: got %0d bytes expected 10", n_valid); end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_rs, bus.out_data} !== {2'b11, 8'h20}) begin
      failures++;
      $display("[TB] FAIL byte10_stalled: got valid/rs/data %b/%b/%h expected 1/1/20",
               bus.out_valid, bus.out_rs, bus.out_data);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if ({bus.out_rs, bus.out_data, bus.busy, bus.frame_done} !== 11'h000) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: got rs/data/busy/done %b/%h/%b/%b expected 0/00/0/0",
               bus.out_rs, bus.out_data, bus.busy, bus.frame_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1;
    cap_q.delete();
    model_blank();
    fd_cycle = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        fd_cycle = c;
        break;
      end
    end
    checks++;
    if (fd_cycle != 35) begin failures++; $display("[TB] FAIL post_reset_done_cycle: got %0d expected 35", fd_cycle); end
    checks++;
    if (cap_q.size() != 34) begin failures++; $display("[TB] FAIL post_reset_len: got %0d expected 34", cap_q.size()); end
    for (int k = 0; k < 34; k++) begin
      got = (k < cap_q.size()) ? cap_q[k] : 9'h000;
      checks++;
      if (got !== exp_byte(k)) begin failures++; $display("[TB] FAIL post_reset_byte%0d: got %h expected %h", k + 1, got, exp_byte(k)); end
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL post_reset_drain: got busy expected idle"); end
  endtask

  initial begin
    test_reset();
    test_write_idle();
    test_backpressure();
    test_midframe_write();
    test_clear_write();
    test_out_of_range();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
